if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised IF/ID boundary with a DEPTH-entry queue of {npc, instr} pairs. It sits between the fetch stage (PC plus I-cache) and decode.
- Replaces the single hit-gated register with:
  - a valid/ready handshake on both sides,
  - decode back-pressure (stall),
  - branch-redirect flush,
  - NOP bubble injection when empty.
- Lets fetch run ahead of a stalled decode by up to DEPTH instructions.

Parameters:
- XLEN, 32, width of npc and instr.
- DEPTH, 2, number of queue entries. Legal range 1..8; need not be a power of 2.
- NOP, 32'h00000000, instruction word presented on out_instr when the queue is empty.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  branch/jump redirect; discards all queued and incoming entries.
- in_valid  input  1  fetch word present, i.e. the I-cache hit qualifier from fetch.
- in_npc  input  XLEN  PC+4 of the fetched instruction.
- in_instr  input  XLEN  fetched instruction word.
- in_ready  output  1  queue can accept an entry this cycle.
- out_valid  output  1  head entry valid for decode.
- out_npc  output  XLEN  head npc.
- out_instr  output  XLEN  head instruction.
- out_ready  input  1  decode consumes head this cycle (low = decode stall).
- occupancy  output  4  number of valid entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry circular buffer, plus:
  - head (rd_ptr) and tail (wr_ptr), each 3 bits wide;
  - an occupancy counter.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0 on increment. Modulo-DEPTH wrap is explicit, not bit overflow.
- Handshake signals:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (occupancy != DEPTH). It depends on registered state only and has no combinational path from out_ready.
  - out_valid = (occupancy != 0).
- Output path:
  - out_npc/out_instr are driven combinationally from entry[rd_ptr] when out_valid=1.
  - When the queue is empty, out_npc = 0 and out_instr = NOP, so decode sees a bubble.
- Latency:
  - An entry pushed on edge N is visible on out_* after edge N (one cycle).
  - There is no bypass from the in_* ports to the out_* ports.
- Update priority at each posedge:
  1. rst.
  2. flush.
  3. push/pop.
- rst=1:
  - rd_ptr, wr_ptr and occupancy are cleared to 0, and all entries are cleared to {0, NOP}.
  - After reset: out_valid=0, out_npc=0, out_instr=NOP, in_ready=1, occupancy=0.
  - Reset mid-stall discards all contents.
- flush=1 (rst=0):
  - Pointers and occupancy are cleared to 0.
  - Any simultaneous push is dropped and any simultaneous pop is ignored.
  - Entry contents need not be cleared.
  - The next cycle shows out_valid=0 and in_ready=1.
- Push and pop, same cycle:
  - Occupancy is unchanged and both pointers advance.
  - Not possible when full, because in_ready=0; the full queue simply pops.
  - When empty, pop=0, so push alone occurs.
- Push only: write entry[wr_ptr], wr_ptr++, occupancy++.
- Pop only: rd_ptr++, occupancy--.
- in_valid=0 (cache miss): no push occurs. Decode drains the existing entries and then sees NOP bubbles.
- in_valid while in_ready=0: the entry is not accepted. Fetch must hold its PC, since it is responsible for re-presenting the entry.
- DEPTH=1: the block degenerates to a single register with a valid bit. in_ready = !out_valid.

Test Plan:
- Reset then idle: rst high 2 cycles, in_valid=0 → out_valid=0, out_instr=NOP, out_npc=0, occupancy=0, in_ready=1.
- Streaming: out_ready=1; push npc=4/8/12 with instr A1,A2,A3 on consecutive cycles → each appears one cycle after its push; occupancy stays at 1 during streaming; no loss or reordering.
- Stall fill (DEPTH=2):
  - out_ready=0; push npc=0x10 then npc=0x14 → occupancy=2, in_ready=0.
  - A third in_valid with npc=0x18 is not accepted.
  - Raise out_ready → 0x10 then 0x14 pop in order.
  - 0x18 is accepted once in_ready=1 and fetch re-presents it.
- Flush with simultaneous push: occupancy=2, flush=1 together with in_valid=1, npc=0x40 → next cycle out_valid=0, occupancy=0; 0x40 never appears on out_npc.
- Miss bubble: out_ready=1; push npc=0x20, then 3 cycles of in_valid=0 → one valid cycle with npc=0x20, then out_instr=NOP and out_valid=0 for 3 cycles.
- Wrap and odd depth (DEPTH=3): 10 pushes with alternating out_ready over 20 cycles → output sequence equals the input sequence; pointers wrap 2→0; occupancy never exceeds 3.
- Mid-operation reset: rst=1 while occupancy=2 → next cycle empty, with reset output values.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID boundary queue: DEPTH-entry FIFO of {npc, instr} pairs between fetch and decode.
// One-cycle push-to-head latency with no bypass; in_ready is driven only by registered occupancy.
module if_id_queue #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 2,
  parameter logic [XLEN-1:0] NOP   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_npc,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_npc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready,
  output logic [3:0]      occupancy
);

  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] LAST = 3'(DEPTH - 1);
  localparam logic [3:0] FULL = 4'(DEPTH);

  logic [XLEN-1:0] npc_q   [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [2:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      wr_ptr_q, wr_ptr_d;
  logic [3:0]      occ_q, occ_d;
  logic            push, pop;

  // Wrap is modulo DEPTH, so odd depths never index past the last entry.
  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == LAST) ? 3'd0 : p + 3'd1;
  endfunction

  assign in_ready  = (occ_q != FULL);
  assign out_valid = (occ_q != 4'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = occ_q;
  assign out_npc   = out_valid ? npc_q[rd_ptr_q[AW-1:0]]   : '0;
  assign out_instr = out_valid ? instr_q[rd_ptr_q[AW-1:0]] : NOP;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      rd_ptr_d = 3'd0;
      wr_ptr_d = 3'd0;
      occ_d    = 4'd0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + 4'd1;
        2'b01:   occ_d = occ_q - 4'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 3'd0;
      wr_ptr_q <= 3'd0;
      occ_q    <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        npc_q[i]   <= '0;
        instr_q[i] <= NOP;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      // A redirect drops the word fetched in the same cycle.
      if (push && !flush) begin
        npc_q[wr_ptr_q[AW-1:0]]   <= in_npc;
        instr_q[wr_ptr_q[AW-1:0]] <= in_instr;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Drives a DEPTH=2 and a DEPTH=3 queue from one stimulus stream and checks both against queue models.
module tb_if_id_queue;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_npc, in_instr;

  logic        rdy2, vld2, rdy3, vld3;
  logic [31:0] npc2, ins2, npc3, ins3;
  logic [3:0]  occ2, occ3;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] q2[$];
  logic [63:0] q3[$];

  always #5 clk = ~clk;

  if_id_queue #(.XLEN(32), .DEPTH(2), .NOP(NOP_W)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_npc(in_npc),
    .in_instr(in_instr), .in_ready(rdy2), .out_valid(vld2), .out_npc(npc2),
    .out_instr(ins2), .out_ready(out_ready), .occupancy(occ2)
  );

  if_id_queue #(.XLEN(32), .DEPTH(3), .NOP(NOP_W)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_npc(in_npc),
    .in_instr(in_instr), .in_ready(rdy3), .out_valid(vld3), .out_npc(npc3),
    .out_instr(ins3), .out_ready(out_ready), .occupancy(occ3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Expected outputs come straight from the model queue contents.
  task automatic check_all(input string ph);
    logic [63:0] h2, h3;
    h2 = (q2.size() != 0) ? q2[0] : {32'h0, NOP_W};
    h3 = (q3.size() != 0) ? q3[0] : {32'h0, NOP_W};
    chk({ph, ".d2.vld"}, 32'(vld2), 32'(q2.size() != 0));
    chk({ph, ".d2.rdy"}, 32'(rdy2), 32'(q2.size() < 2));
    chk({ph, ".d2.occ"}, 32'(occ2), 32'(q2.size()));
    chk({ph, ".d2.npc"}, npc2, h2[63:32]);
    chk({ph, ".d2.ins"}, ins2, h2[31:0]);
    chk({ph, ".d3.vld"}, 32'(vld3), 32'(q3.size() != 0));
    chk({ph, ".d3.rdy"}, 32'(rdy3), 32'(q3.size() < 3));
    chk({ph, ".d3.occ"}, 32'(occ3), 32'(q3.size()));
    chk({ph, ".d3.npc"}, npc3, h3[63:32]);
    chk({ph, ".d3.ins"}, ins3, h3[31:0]);
  endtask

  // One clock: apply inputs, advance both models at the edge, check at the falling edge.
  task automatic cyc(input string ph, input logic r, input logic f, input logic iv,
                     input logic [31:0] npc, input logic [31:0] ins, input logic ordy);
    bit pop2, push2, pop3, push3;
    rst = r; flush = f; in_valid = iv; in_npc = npc; in_instr = ins; out_ready = ordy;
    @(posedge clk);
    pop2  = (q2.size() != 0) && ordy;
    push2 = iv && (q2.size() < 2);
    pop3  = (q3.size() != 0) && ordy;
    push3 = iv && (q3.size() < 3);
    if (r || f) begin
      q2.delete();
      q3.delete();
    end else begin
      if (pop2)  void'(q2.pop_front());
      if (push2) q2.push_back({npc, ins});
      if (pop3)  void'(q3.pop_front());
      if (push3) q3.push_back({npc, ins});
    end
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_npc = '0; in_instr = '0;
    @(negedge clk);

    // reset then idle
    cyc("rst", 1, 0, 0, 0, 0, 0);
    cyc("rst", 1, 0, 0, 0, 0, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0);

    // streaming with decode always ready
    cyc("strm", 0, 0, 1, 32'h4,  32'hA1, 1);
    cyc("strm", 0, 0, 1, 32'h8,  32'hA2, 1);
    cyc("strm", 0, 0, 1, 32'hC,  32'hA3, 1);
    cyc("strm", 0, 0, 0, 0, 0, 1);

    // stall fill, rejected third word, drain, re-present
    cyc("fill", 0, 0, 1, 32'h10, 32'hB0, 0);
    cyc("fill", 0, 0, 1, 32'h14, 32'hB1, 0);
    cyc("fill", 0, 0, 1, 32'h18, 32'hB2, 0);
    cyc("fill", 0, 0, 1, 32'h1C, 32'hB3, 0);
    cyc("drain", 0, 0, 1, 32'h18, 32'hB2, 1);
    cyc("drain", 0, 0, 1, 32'h18, 32'hB2, 1);
    cyc("drain", 0, 0, 0, 0, 0, 1);
    cyc("drain", 0, 0, 0, 0, 0, 1);
    cyc("drain", 0, 0, 0, 0, 0, 1);

    // flush while full together with a push
    cyc("fl", 0, 0, 1, 32'h30, 32'hC0, 0);
    cyc("fl", 0, 0, 1, 32'h34, 32'hC1, 0);
    cyc("fl", 0, 1, 1, 32'h40, 32'hC2, 1);
    cyc("fl", 0, 0, 0, 0, 0, 1);

    // miss bubble
    cyc("miss", 0, 0, 1, 32'h20, 32'hD0, 1);
    for (int i = 0; i < 3; i++) cyc("miss", 0, 0, 0, 0, 0, 1);

    // wrap with alternating decode readiness
    for (int i = 0; i < 20; i++)
      cyc("wrap", 0, 0, (i < 10), 32'h100 + 32'(4 * i), 32'hE000 + 32'(i), i[0]);
    for (int i = 0; i < 6; i++) cyc("wrap", 0, 0, 0, 0, 0, 1);

    // reset while holding entries
    cyc("mrst", 0, 0, 1, 32'h50, 32'hF0, 0);
    cyc("mrst", 0, 0, 1, 32'h54, 32'hF1, 0);
    cyc("mrst", 1, 0, 0, 0, 0, 0);
    cyc("mrst", 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++)
      cyc("rnd", ($urandom_range(99) < 2), ($urandom_range(99) < 5),
          ($urandom_range(99) < 70), $urandom, $urandom, ($urandom_range(99) < 55));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
